// File: rtl/multi_digit_counter_display.sv
// Multi-digit BCD/hex up/down counter with a time-multiplexed seven-segment display.
// The count steps once per prescaled tick, and the display scans one digit at a time.
module multi_digit_counter_display #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 12000000,
  parameter int unsigned SCAN_DIV = 12000,
  parameter int unsigned BCD      = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  up,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   value,
  output logic                  tick,
  output logic                  wrap,
  output logic [6:0]            abcdefg,
  output logic [DIGITS-1:0]     digit_sel
);

  localparam int unsigned VW = 4 * DIGITS;
  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [3:0]    DIG_MAX   = (BCD != 0) ? 4'h9 : 4'hF;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [VW-1:0]     r_value;
  logic [TW-1:0]     r_tick_cnt;
  logic              r_tick;
  logic              r_wrap;
  logic [SW-1:0]     r_scan_cnt;
  logic [IW-1:0]     r_scan_idx;
  logic [6:0]        r_abcdefg;
  logic [DIGITS-1:0] r_digit_sel;

  logic              w_step;
  logic [VW-1:0]     w_next_value;
  logic              w_carry;
  logic              w_wrap;
  logic [VW-1:0]     w_load_sat;
  logic              w_scan_term;
  logic [IW-1:0]     w_next_idx;
  logic [3:0]        w_scan_nib;

  function automatic logic [6:0] f_glyph(input logic [3:0] d);
    case (d)
      4'h0: f_glyph = 7'h7E;
      4'h1: f_glyph = 7'h30;
      4'h2: f_glyph = 7'h6D;
      4'h3: f_glyph = 7'h79;
      4'h4: f_glyph = 7'h33;
      4'h5: f_glyph = 7'h5B;
      4'h6: f_glyph = 7'h5F;
      4'h7: f_glyph = 7'h70;
      4'h8: f_glyph = 7'h7F;
      4'h9: f_glyph = 7'h7B;
      4'hA: f_glyph = 7'h77;
      4'hB: f_glyph = 7'h1F;
      4'hC: f_glyph = 7'h4E;
      4'hD: f_glyph = 7'h3D;
      4'hE: f_glyph = 7'h4F;
      4'hF: f_glyph = 7'h47;
    endcase
  endfunction

  assign w_step = enable && (r_tick_cnt == TICK_LAST);

  // Per-nibble increment/decrement; carry/borrow out of the top digit is the wrap.
  always_comb begin
    w_next_value = r_value;
    w_carry      = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (w_carry) begin
        if (up) begin
          if (r_value[4*i +: 4] == DIG_MAX) begin
            w_next_value[4*i +: 4] = 4'h0;
          end else begin
            w_next_value[4*i +: 4] = r_value[4*i +: 4] + 4'h1;
            w_carry                = 1'b0;
          end
        end else begin
          if (r_value[4*i +: 4] == 4'h0) begin
            w_next_value[4*i +: 4] = DIG_MAX;
          end else begin
            w_next_value[4*i +: 4] = r_value[4*i +: 4] - 4'h1;
            w_carry                = 1'b0;
          end
        end
      end
    end
    w_wrap = w_carry;
  end

  // Loaded nibbles above the digit maximum saturate (only reachable in BCD mode).
  always_comb begin
    w_load_sat = load_value;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (load_value[4*i +: 4] > DIG_MAX) begin
        w_load_sat[4*i +: 4] = DIG_MAX;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_value    <= '0;
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      if (clear) begin
        r_value    <= '0;
        r_tick_cnt <= '0;
      end else begin
        if (enable) begin
          r_tick_cnt <= w_step ? TW'(0) : r_tick_cnt + TW'(1);
        end
        if (load) begin
          r_value <= w_load_sat;
        end else if (w_step) begin
          r_value <= w_next_value;
          r_tick  <= 1'b1;
          r_wrap  <= w_wrap;
        end
      end
    end
  end

  assign w_scan_term = (r_scan_cnt == SCAN_LAST);
  assign w_next_idx  = w_scan_term ? ((r_scan_idx == IDX_LAST) ? IW'(0) : r_scan_idx + IW'(1))
                                   : r_scan_idx;
  assign w_scan_nib  = r_value[{w_next_idx, 2'b00} +: 4];

  // Select and segments come from the same next index, so they always agree.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_scan_cnt  <= '0;
      r_scan_idx  <= '0;
      r_digit_sel <= DIGITS'(1);
      r_abcdefg   <= 7'h7E;
    end else begin
      r_scan_cnt  <= w_scan_term ? SW'(0) : r_scan_cnt + SW'(1);
      r_scan_idx  <= w_next_idx;
      r_digit_sel <= DIGITS'(1) << w_next_idx;
      r_abcdefg   <= f_glyph(w_scan_nib);
    end
  end

  assign value     = r_value;
  assign tick      = r_tick;
  assign wrap      = r_wrap;
  assign abcdefg   = r_abcdefg;
  assign digit_sel = r_digit_sel;

endmodule
